seq_pattern_detector: RTL and testbench
=======================================

// Module: seq_pattern_detector
// PURPOSE
//  Serial bit-pattern detector with a runtime-programmable pattern, length and overlap mode.
//  Generalises the fixed 101001 cycle detector to any pattern of 1..MAX_LEN bits.
//  Adds an input qualifier and a saturating match counter.
//  Sits after a serial sampler in the FSM lab designs; its one-cycle detect pulse feeds counters or interrupts.
// PARAMETERS
//  MAX_LEN      8          maximum pattern length in bits (>=2)
//  CNT_W        8          width of match_count
//  DEF_PATTERN  8'h29      reset pattern, right-aligned (6'b101001)
//  DEF_LEN      6          reset pattern length
//  DEF_OVERLAP  1          reset overlap mode
// PORTS
//  clk          in   1                 clock, rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  cfg_we       in   1                 load cfg_* into config registers
//  cfg_pattern  in   MAX_LEN           pattern, right-aligned; bit[len-1] is received first
//  cfg_len      in   $clog2(MAX_LEN+1) pattern length
//  cfg_overlap  in   1                 1 = overlapping matches allowed
//  in_valid     in   1                 in_bit is valid this cycle
//  in_bit       in   1                 serial data bit
//  detected     out  1                 one-cycle match pulse (registered)
//  match_count  out  CNT_W             saturating count of matches
//  armed        out  1                 history holds >= len valid bits
// BEHAVIOUR
//  Reset (rst_n=0, async): detected=0, match_count=0, armed=0, hist=0, fill=0.
//   Config regs take DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
//  State: hist[MAX_LEN-1:0] shift register, fill counter 0..MAX_LEN, config regs pat/len/ovl.
//  Accept: on in_valid=1 and cfg_we=0: hist<={hist[MAX_LEN-2:0],in_bit}; fill<=min(fill+1,MAX_LEN).
//  Match: computed on the post-shift history.
//   Condition: (fill_next>=len) && (hist_next[len-1:0]==pat[len-1:0]).
//   On match, detected=1 in the cycle after the last pattern bit is sampled (latency 1 clk).
//  detected is 0 in every cycle with no accepted bit, or with an accepted bit and no match.
//  Overlap mode: ovl=1 keeps history after a match. ovl=0 forces fill<=0 on a match, so the next match needs len fresh bits.
//  match_count increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
//  armed = (fill>=len) && (len!=0).
//  cfg_we=1 loads pat/len/ovl and clears hist, fill and detected.
//   match_count is preserved.
//   cfg_we has priority over a simultaneous in_valid; that bit is dropped.
//  cfg_len=0 disables detection: detected stays 0 and the counter does not change.
//  cfg_len>MAX_LEN is clamped to MAX_LEN when loaded.
//  in_valid=0 freezes all state; gaps between valid bits do not break a pattern.
//  Reset asserted mid-pattern discards the partial history.
// CONFIGURATION
//  SEQ_DET_MASK_EN defined:
//   - Adds input cfg_mask[MAX_LEN-1:0], loaded with cfg_we (reset value all-ones).
//   - Only positions with mask=1 are compared; mask=0 bits are don't-care.
//   - fill/len rules are unchanged.
//  SEQ_DET_MASK_EN undefined: the port is absent and all len bits are compared exactly.
// TESTING
//  T1 default cfg: bits 1,0,1,0,0,1 -> detected=1 one clk after 6th bit; match_count=1.
//  T2 overlap: default cfg, stream 1,0,1,0,0,1,0,1,0,0,1 -> 2 pulses (after bits 6 and 11); count=2.
//  T3 non-overlap: pat=3'b101, len=3, ovl=0, stream 1,0,1,0,1 -> 1 pulse (bit 3).
//     Same stream with ovl=1 -> 2 pulses (bits 3 and 5).
//  T4 gaps/cfg: default pattern sent with in_valid low 2 clks between bits -> still 1 pulse.
//     cfg_we during the 4th bit -> no pulse, that bit dropped; armed=0.
//  T5 saturation: CNT_W=2, pat=1'b1, len=1, 5 ones -> 5 pulses; match_count stops at 3.
//  T6 reset mid-pattern: bits 1,0,1; rst_n low 1 clk; then 0,0,1 -> no pulse; all outputs 0 after reset.
//  Mask (SEQ_DET_MASK_EN): pat=4'b1001, mask=4'b1001, len=4 -> streams 1,0,0,1 and 1,1,1,1 each pulse once.

Source files
------------

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: runtime-programmable serial pattern detector; define SEQ_DET_MASK_EN for a per-bit compare mask
module seq_pattern_detector #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'h29,
   parameter int                 DEF_LEN     = 6,
   parameter logic               DEF_OVERLAP = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_we,
   input  logic [MAX_LEN-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
   input  logic                           cfg_overlap,
`ifdef SEQ_DET_MASK_EN
   input  logic [MAX_LEN-1:0]             cfg_mask,
`endif
   input  logic                           in_valid,
   input  logic                           in_bit,
   output logic                           detected,
   output logic [CNT_W-1:0]               match_count,
   output logic                           armed
);
   localparam int LW = $clog2(MAX_LEN+1);
   logic [MAX_LEN-1:0] hist, pat, len_mask, cmp_mask, hist_next;
   logic [LW-1:0]      fill, len, fill_next, len_load;
   logic               ovl, accept, match;
`ifdef SEQ_DET_MASK_EN
   logic [MAX_LEN-1:0] msk;
`endif

   assign armed = (fill >= len) && (len != '0);

   // Post-shift history, saturating fill and match decision for the bit being accepted
   always_comb begin
      accept    = in_valid && !cfg_we;
      hist_next = (hist << 1) | MAX_LEN'(in_bit);
      fill_next = (fill == LW'(MAX_LEN)) ? fill : fill + LW'(1);
      len_mask  = ~({MAX_LEN{1'b1}} << len);
`ifdef SEQ_DET_MASK_EN
      cmp_mask  = len_mask & msk;
`else
      cmp_mask  = len_mask;
`endif
      match     = accept && (len != '0) && (fill_next >= len) && (((hist_next ^ pat) & cmp_mask) == '0);
      len_load  = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
   end

   // Config load has priority; otherwise shift in accepted bits, pulse and count matches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat         <= DEF_PATTERN;
         len         <= LW'(DEF_LEN);
         ovl         <= DEF_OVERLAP;
         hist        <= '0;
         fill        <= '0;
         detected    <= 1'b0;
         match_count <= '0;
`ifdef SEQ_DET_MASK_EN
         msk         <= '1;
`endif
      end else if (cfg_we) begin
         pat      <= cfg_pattern;
         len      <= len_load;
         ovl      <= cfg_overlap;
         hist     <= '0;
         fill     <= '0;
         detected <= 1'b0;
`ifdef SEQ_DET_MASK_EN
         msk      <= cfg_mask;
`endif
      end else begin
         detected <= match;
         if (in_valid) begin
            hist <= hist_next;
            fill <= (match && !ovl) ? '0 : fill_next;
         end
         if (match && match_count != '1)
            match_count <= match_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: vector table plus hand sequences for the pattern detector
module tb_seq_pattern_detector;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we, cfg_overlap, in_valid, in_bit;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
`ifdef SEQ_DET_MASK_EN
   logic [7:0] cfg_mask;
`endif
   logic       detected, armed, sat_det, sat_arm;
   logic [7:0] match_count;
   logic [1:0] sat_cnt;

   typedef struct {
      int we; int pat; int len; int ovl; int v; int b;
      int det; int cnt; int arm;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   passed = 0;
   int   total = 0;
   int   n = 0;

   always #5 clk = ~clk;

   seq_pattern_detector u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .in_valid(in_valid), .in_bit(in_bit),
      .detected(detected), .match_count(match_count), .armed(armed)
   );

   seq_pattern_detector #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
`ifdef SEQ_DET_MASK_EN
      .cfg_mask(cfg_mask),
`endif
      .in_valid(in_valid), .in_bit(in_bit),
      .detected(sat_det), .match_count(sat_cnt), .armed(sat_arm)
   );

   function automatic void check(string name, int act, int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s step %0d: got %0d, expected %0d", name, n, act, exp);
   endfunction

   function automatic vec_t mk(int we, int pat, int len, int ovl, int v, int b, int det, int cnt, int arm);
      vec_t t;
      t.we = we; t.pat = pat; t.len = len; t.ovl = ovl; t.v = v; t.b = b;
      t.det = det; t.cnt = cnt; t.arm = arm;
      return t;
   endfunction

   function automatic void add(int we, int pat, int len, int ovl, int v, int b, int det, int cnt, int arm);
      vecs.push_back(mk(we, pat, len, ovl, v, b, det, cnt, arm));
   endfunction

   task automatic step(input vec_t v);
      vec_t e;
      cfg_we      = 1'(v.we);
      cfg_pattern = 8'(v.pat);
      cfg_len     = 4'(v.len);
      cfg_overlap = 1'(v.ovl);
      in_valid    = 1'(v.v);
      in_bit      = 1'(v.b);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("detected", int'(detected), e.det);
      check("match_count", int'(match_count), e.cnt);
      check("armed", int'(armed), e.arm);
      n++;
   endtask

   task automatic check_reset();
      check("rst_detected", int'(detected), 0);
      check("rst_match_count", int'(match_count), 0);
      check("rst_armed", int'(armed), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [10:0] s;
      logic [5:0]  p;
      logic [4:0]  q;
      logic [7:0]  c;
      logic [3:0]  m;
      rst_n = 1'b1;
      cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0;
`ifdef SEQ_DET_MASK_EN
      cfg_mask = 8'hFF;
`endif
      #2 rst_n = 1'b0;
      #10;
      check_reset();
      check("rst_sat_count", int'(sat_cnt), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      s = 11'b10100101001;
      for (int i = 0; i < 11; i++)
         add(0, 'h29, 6, 1, 1, int'(s[10-i]), (i == 5 || i == 10) ? 1 : 0,
             (i < 5) ? 0 : (i < 10) ? 1 : 2, (i >= 5) ? 1 : 0);
      add(0, 'h29, 6, 1, 0, 0, 0, 2, 1);
      add(1, 'h29, 6, 1, 0, 0, 0, 2, 0);
      p = 6'b101001;
      for (int i = 0; i < 6; i++) begin
         add(0, 'h29, 6, 1, 1, int'(p[5-i]), (i == 5) ? 1 : 0, (i == 5) ? 3 : 2, (i == 5) ? 1 : 0);
         add(0, 'h29, 6, 1, 0, 0, 0, (i == 5) ? 3 : 2, (i == 5) ? 1 : 0);
         add(0, 'h29, 6, 1, 0, 0, 0, (i == 5) ? 3 : 2, (i == 5) ? 1 : 0);
      end
      add(1, 'h29, 6, 1, 0, 0, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 1, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 0, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 1, 0, 3, 0);
      add(1, 'h29, 6, 1, 1, 0, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 0, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 0, 0, 3, 0);
      add(0, 'h29, 6, 1, 1, 1, 0, 3, 0);
      q = 5'b10101;
      add(1, 'h05, 3, 0, 0, 0, 0, 3, 0);
      for (int i = 0; i < 5; i++)
         add(0, 'h05, 3, 0, 1, int'(q[4-i]), (i == 2) ? 1 : 0, (i < 2) ? 3 : 4, 0);
      add(1, 'h05, 3, 1, 0, 0, 0, 4, 0);
      for (int i = 0; i < 5; i++)
         add(0, 'h05, 3, 1, 1, int'(q[4-i]), (i == 2 || i == 4) ? 1 : 0,
             (i < 2) ? 4 : (i < 4) ? 5 : 6, (i >= 2) ? 1 : 0);
      add(1, 'h05, 0, 1, 0, 0, 0, 6, 0);
      add(0, 'h05, 0, 1, 1, 1, 0, 6, 0);
      add(0, 'h05, 0, 1, 1, 1, 0, 6, 0);
      add(0, 'h05, 0, 1, 1, 0, 0, 6, 0);
      c = 8'hA5;
      add(1, 'hA5, 15, 1, 0, 0, 0, 6, 0);
      for (int i = 0; i < 8; i++)
         add(0, 'hA5, 15, 1, 1, int'(c[7-i]), (i == 7) ? 1 : 0, (i == 7) ? 7 : 6, (i == 7) ? 1 : 0);
      foreach (vecs[i]) step(vecs[i]);
      rst_n = 1'b0;
      #2;
      check_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(0, 'h29, 6, 1, 1, 1, 0, 0, 0));
      step(mk(0, 'h29, 6, 1, 1, 0, 0, 0, 0));
      step(mk(0, 'h29, 6, 1, 1, 1, 0, 0, 0));
      rst_n = 1'b0;
      #2;
      check_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(0, 'h29, 6, 1, 1, 0, 0, 0, 0));
      step(mk(0, 'h29, 6, 1, 1, 0, 0, 0, 0));
      step(mk(0, 'h29, 6, 1, 1, 1, 0, 0, 0));
      step(mk(1, 'h01, 1, 1, 0, 0, 0, 0, 0));
      check("sat_count", int'(sat_cnt), 0);
      for (int k = 1; k <= 5; k++) begin
         step(mk(0, 'h01, 1, 1, 1, 1, 1, k, 1));
         check("sat_count", int'(sat_cnt), (k < 3) ? k : 3);
         check("sat_detected", int'(sat_det), 1);
         check("sat_armed", int'(sat_arm), 1);
      end
      step(mk(0, 'h01, 1, 1, 1, 0, 0, 5, 1));
      check("sat_count", int'(sat_cnt), 3);
`ifdef SEQ_DET_MASK_EN
      cfg_mask = 8'h09;
      step(mk(1, 'h09, 4, 0, 0, 0, 0, 5, 0));
      m = 4'b1001;
      for (int i = 0; i < 4; i++)
         step(mk(0, 'h09, 4, 0, 1, int'(m[3-i]), (i == 3) ? 1 : 0, (i == 3) ? 6 : 5, 0));
      for (int i = 0; i < 4; i++)
         step(mk(0, 'h09, 4, 0, 1, 1, (i == 3) ? 1 : 0, (i == 3) ? 7 : 6, 0));
`else
      m = 4'b0000;
      check("mask_unused", int'(m), 0);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
